// File: rtl/sa_sched_pkg.sv
// Shared types and helpers for the network layer scheduler.
package sa_sched_pkg;

    // Width of the layer index handed to the SA controller.
    localparam int SA_NTH_W   = 2;
    // Widest tile counter the helper below accepts.
    localparam int MAX_TILE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WLOAD = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    // True when another tile of the current layer remains after 'tile'.
    function automatic logic more_tiles(input logic [MAX_TILE_W-1:0] tile,
                                        input logic [MAX_TILE_W-1:0] count);
        return ({1'b0, tile} + 17'd1) < {1'b0, count};
    endfunction

endpackage

// File: rtl/sa_watchdog.sv
// Run-time watchdog: cleared outside RUN, counts while enabled, flags the
// last permitted cycle so the scheduler can abandon a hung SA run.
module sa_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has precedence over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/sa_layer_sched.sv
// Network-level scheduler: walks the conv layers, prefetches weights and
// starts the SA per tile, flushes outputs per layer, pulses done per network.
// valid/ready style: wgt_req_o and flush_req_o are levels held until their
// ack/done input is sampled high in the owning state; sa_start_o and done_o
// are single-cycle pulses with no back-pressure.
module sa_layer_sched
    import sa_sched_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int TILE_W     = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [NUM_LAYERS*TILE_W-1:0] cfg_tiles_i,
    output logic                         wgt_req_o,
    input  logic                         wgt_ack_i,
    output logic                         sa_start_o,
    output logic [SA_NTH_W-1:0]          sa_nth_conv_o,
    input  logic                         sa_done_i,
    output logic [TILE_W-1:0]            tile_idx_o,
    output logic                         flush_req_o,
    input  logic                         flush_done_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
);
    localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CFG_W   = NUM_LAYERS * TILE_W;

    sched_state_e        state_q, state_d;
    logic [LAYER_W-1:0]  layer_q, layer_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic [CFG_W-1:0]    cfg_q, cfg_d;
    logic                err_q, err_d;
    logic                wgt_req_q, wgt_req_d;
    logic                sa_start_q, sa_start_d;
    logic                flush_req_q, flush_req_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                first_found, next_found;
    logic [LAYER_W-1:0]  first_idx, next_idx;
    logic [TILE_W-1:0]   cur_tiles;
    logic                wdog_expire;

    sa_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q != ST_RUN),
        .en_i     (state_q == ST_RUN),
        .expire_o (wdog_expire)
    );

    // Layer search (lowest non-zero layer wins) and current-layer tile count.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        cur_tiles   = '0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (cfg_tiles_i[k*TILE_W +: TILE_W] != '0) begin
                first_found = 1'b1;
                first_idx   = LAYER_W'(k);
            end
            if ((k > int'(layer_q)) && (cfg_q[k*TILE_W +: TILE_W] != '0)) begin
                next_found = 1'b1;
                next_idx   = LAYER_W'(k);
            end
            if (LAYER_W'(k) == layer_q) begin
                cur_tiles = cfg_q[k*TILE_W +: TILE_W];
            end
        end
    end

    // Next state, counters and registered-output values.
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        tile_d  = tile_q;
        cfg_d   = cfg_q;
        err_d   = err_q;
        if (abort_i) begin
            state_d = ST_IDLE;
            layer_d = '0;
            tile_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        cfg_d  = cfg_tiles_i;
                        err_d  = 1'b0;
                        tile_d = '0;
                        if (first_found) begin
                            state_d = ST_WLOAD;
                            layer_d = first_idx;
                        end else begin
                            state_d = ST_DONE;
                            layer_d = '0;
                        end
                    end
                end
                ST_WLOAD: begin
                    if (wgt_ack_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sa_done_i) begin
                        if (more_tiles(MAX_TILE_W'(tile_q), MAX_TILE_W'(cur_tiles))) begin
                            state_d = ST_WLOAD;
                            tile_d  = tile_q + TILE_W'(1);
                        end else begin
                            state_d = ST_FLUSH;
                        end
                    end else if (wdog_expire) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        layer_d = '0;
                        tile_d  = '0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_done_i) begin
                        if (next_found) begin
                            state_d = ST_WLOAD;
                            layer_d = next_idx;
                            tile_d  = '0;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    layer_d = '0;
                    tile_d  = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    layer_d = '0;
                    tile_d  = '0;
                end
            endcase
        end

        wgt_req_d   = (state_d == ST_WLOAD);
        sa_start_d  = (state_q == ST_WLOAD) && (state_d == ST_RUN);
        flush_req_d = (state_d == ST_FLUSH);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // State, counters, latched config and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            layer_q     <= '0;
            tile_q      <= '0;
            cfg_q       <= '0;
            err_q       <= 1'b0;
            wgt_req_q   <= 1'b0;
            sa_start_q  <= 1'b0;
            flush_req_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            tile_q      <= tile_d;
            cfg_q       <= cfg_d;
            err_q       <= err_d;
            wgt_req_q   <= wgt_req_d;
            sa_start_q  <= sa_start_d;
            flush_req_q <= flush_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign wgt_req_o     = wgt_req_q;
    assign sa_start_o    = sa_start_q;
    assign sa_nth_conv_o = SA_NTH_W'(layer_q);
    assign tile_idx_o    = tile_q;
    assign flush_req_o   = flush_req_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_sa_layer_sched.sv
// Directed + randomized bench for sa_layer_sched (2 layers, 4-bit tiles, TIMEOUT 16).
module tb_sa_layer_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [7:0] cfg_tiles_i = 8'h00;
    logic       wgt_req_o, sa_start_o, flush_req_o, busy_o, done_o, err_o;
    logic [1:0] sa_nth_conv_o;
    logic [3:0] tile_idx_o;
    logic       wgt_ack_i, sa_done_i, flush_done_i;

    // Responder drives r_*, directed steps drive m_*.
    logic r_ack, r_done, r_fdone;
    logic m_ack = 1'b0, m_done = 1'b0, m_fdone = 1'b0;
    assign wgt_ack_i    = r_ack | m_ack;
    assign sa_done_i    = r_done | m_done;
    assign flush_done_i = r_fdone | m_fdone;

    logic resp_en  = 1'b0;
    logic withhold = 1'b0;
    int   dly      = 3;

    int n_assert = 0;
    int n_fail   = 0;

    // Observations recorded by the monitor.
    logic [5:0] obs_start_q[$];
    logic [1:0] obs_flush_q[$];
    int         req_rise = 0;
    int         done_cnt = 0;

    // Expected events from the reference model.
    logic [5:0] exp_start_q[$];
    logic [1:0] exp_flush_q[$];

    sa_layer_sched #(.NUM_LAYERS(2), .TILE_W(4), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .cfg_tiles_i   (cfg_tiles_i),
        .wgt_req_o     (wgt_req_o),
        .wgt_ack_i     (wgt_ack_i),
        .sa_start_o    (sa_start_o),
        .sa_nth_conv_o (sa_nth_conv_o),
        .sa_done_i     (sa_done_i),
        .tile_idx_o    (tile_idx_o),
        .flush_req_o   (flush_req_o),
        .flush_done_i  (flush_done_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    // Clock.
    always #5 clk = ~clk;

    // Responder: answers each request/start 'dly' cycles later.
    initial begin : responder
        int w_cnt, r_cnt, f_cnt;
        w_cnt = 0; r_cnt = 0; f_cnt = 0;
        r_ack = 1'b0; r_done = 1'b0; r_fdone = 1'b0;
        forever begin
            @(negedge clk);
            r_ack = 1'b0; r_done = 1'b0; r_fdone = 1'b0;
            if (!resp_en || rst) begin
                w_cnt = 0; r_cnt = 0; f_cnt = 0;
            end else begin
                if (wgt_req_o) begin
                    w_cnt++;
                    if (w_cnt >= dly) begin r_ack = 1'b1; w_cnt = 0; end
                end else w_cnt = 0;
                if (sa_start_o) r_cnt = 1;
                else if (r_cnt > 0) r_cnt++;
                if (withhold) r_cnt = 0;
                else if (r_cnt > 0 && r_cnt >= dly) begin r_done = 1'b1; r_cnt = 0; end
                if (flush_req_o) begin
                    f_cnt++;
                    if (f_cnt >= dly) begin r_fdone = 1'b1; f_cnt = 0; end
                end else f_cnt = 0;
            end
        end
    end

    // Monitor: records start pulses, request/flush rises and done pulses.
    initial begin : monitor
        logic prev_w, prev_f;
        prev_w = 1'b0; prev_f = 1'b0;
        forever begin
            @(negedge clk);
            if (sa_start_o) obs_start_q.push_back({sa_nth_conv_o, tile_idx_o});
            if (wgt_req_o && !prev_w) req_rise++;
            if (flush_req_o && !prev_f) obs_flush_q.push_back(sa_nth_conv_o);
            if (done_o) done_cnt++;
            prev_w = wgt_req_o;
            prev_f = flush_req_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then scramble cfg to prove it was latched.
    task automatic pulse_start(input logic [7:0] cfg);
        @(negedge clk);
        cfg_tiles_i = cfg;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
        cfg_tiles_i = 8'($urandom);
    endtask

    task automatic wait_req(input string tag);
        int b;
        b = 0;
        while (!wgt_req_o && b < 50) begin @(negedge clk); b++; end
        check({tag, " req_seen"}, 32'(wgt_req_o), 32'd1);
    endtask

    // Full network against the model: every non-zero layer k gives tiles
    // (k,0..n-1) in order, then one flush tagged k; finally one done.
    task automatic run_network(input logic [7:0] cfg, input int d, input string tag);
        int s_base, f_base, r_base, d_base, b;
        exp_start_q.delete();
        exp_flush_q.delete();
        for (int k = 0; k < 2; k++) begin
            int n;
            n = int'(cfg[k*4 +: 4]);
            for (int t = 0; t < n; t++) exp_start_q.push_back({2'(k), 4'(t)});
            if (n > 0) exp_flush_q.push_back(2'(k));
        end
        s_base = obs_start_q.size();
        f_base = obs_flush_q.size();
        r_base = req_rise;
        d_base = done_cnt;
        dly     = d;
        resp_en = 1'b1;
        pulse_start(cfg);
        b = 0;
        while (done_cnt == d_base && b < 3000) begin @(negedge clk); b++; end
        check({tag, " done_seen"}, 32'(done_cnt > d_base), 32'd1);
        repeat (3) @(negedge clk);
        resp_en = 1'b0;
        check({tag, " done_count"}, 32'(done_cnt - d_base), 32'd1);
        check({tag, " start_count"}, 32'(obs_start_q.size() - s_base), 32'(exp_start_q.size()));
        for (int i = 0; i < exp_start_q.size() && s_base + i < obs_start_q.size(); i++)
            check($sformatf("%s start[%0d] nth/tile", tag, i), 32'(obs_start_q[s_base + i]), 32'(exp_start_q[i]));
        check({tag, " flush_count"}, 32'(obs_flush_q.size() - f_base), 32'(exp_flush_q.size()));
        for (int i = 0; i < exp_flush_q.size() && f_base + i < obs_flush_q.size(); i++)
            check($sformatf("%s flush[%0d] nth", tag, i), 32'(obs_flush_q[f_base + i]), 32'(exp_flush_q[i]));
        check({tag, " req_count"}, 32'(req_rise - r_base), 32'(exp_start_q.size()));
        check({tag, " err"}, 32'(err_o), 32'd0);
        check({tag, " busy_after"}, 32'(busy_o), 32'd0);
    endtask

    initial begin : main
        int b, cnt, d_base, f_base;

        // Reset.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst wgt_req", 32'(wgt_req_o), 32'd0);
        check("rst sa_start", 32'(sa_start_o), 32'd0);
        check("rst flush_req", 32'(flush_req_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst err", 32'(err_o), 32'd0);
        check("rst nth", 32'(sa_nth_conv_o), 32'd0);
        check("rst tile", 32'(tile_idx_o), 32'd0);

        // Directed networks.
        run_network(8'h61, 3, "L0=1,L1=6");
        run_network(8'h20, 3, "L0=0,L1=2");

        // All layers empty: done one cycle after start, busy only that cycle.
        d_base = done_cnt;
        pulse_start(8'h00);
        check("zero done", 32'(done_o), 32'd1);
        check("zero busy", 32'(busy_o), 32'd1);
        check("zero req", 32'(wgt_req_o), 32'd0);
        @(negedge clk);
        check("zero done_after", 32'(done_o), 32'd0);
        check("zero busy_after", 32'(busy_o), 32'd0);

        // Random networks.
        for (int r = 0; r < 5; r++) begin
            logic [7:0] cfg;
            cfg = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            run_network(cfg, int'($urandom_range(1, 4)), $sformatf("rand%0d cfg=%02h", r, cfg));
        end

        // Watchdog: done withheld.
        d_base   = done_cnt;
        withhold = 1'b1;
        dly      = 2;
        resp_en  = 1'b1;
        pulse_start(8'h01);
        b = 0;
        while (!sa_start_o && b < 50) begin @(negedge clk); b++; end
        check("wdog start_seen", 32'(sa_start_o), 32'd1);
        cnt = 0;
        while (!err_o && cnt < 100) begin @(negedge clk); cnt++; end
        check("wdog err_latency", 32'(cnt), 32'd16);
        check("wdog busy", 32'(busy_o), 32'd0);
        check("wdog no_done", 32'(done_cnt - d_base), 32'd0);
        repeat (2) @(negedge clk);
        check("wdog err_sticky", 32'(err_o), 32'd1);
        resp_en  = 1'b0;
        withhold = 1'b0;
        pulse_start(8'h00);
        check("wdog err_cleared", 32'(err_o), 32'd0);
        check("wdog restart_done", 32'(done_o), 32'd1);
        repeat (2) @(negedge clk);

        // Abort in the same cycle as sa_done.
        d_base = done_cnt;
        f_base = obs_flush_q.size();
        pulse_start(8'h22);
        wait_req("abort");
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        check("abort sa_start", 32'(sa_start_o), 32'd1);
        m_done  = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        m_done  = 1'b0;
        abort_i = 1'b0;
        check("abort busy", 32'(busy_o), 32'd0);
        check("abort wgt_req", 32'(wgt_req_o), 32'd0);
        check("abort flush_req", 32'(flush_req_o), 32'd0);
        check("abort sa_start_off", 32'(sa_start_o), 32'd0);
        repeat (5) @(negedge clk);
        check("abort idle_later", 32'(busy_o | wgt_req_o | flush_req_o), 32'd0);
        check("abort no_done", 32'(done_cnt - d_base), 32'd0);
        check("abort no_flush", 32'(obs_flush_q.size() - f_base), 32'd0);

        // Start while busy is ignored, then async reset mid-WLOAD.
        pulse_start(8'h13);
        wait_req("rstwl");
        cfg_tiles_i = 8'h00;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_start wgt_req", 32'(wgt_req_o), 32'd1);
        check("busy_start busy", 32'(busy_o), 32'd1);
        check("busy_start done", 32'(done_o), 32'd0);
        check("busy_start nth", 32'(sa_nth_conv_o), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst wgt_req", 32'(wgt_req_o), 32'd0);
        check("async_rst busy", 32'(busy_o), 32'd0);
        check("async_rst tile_nth", 32'({sa_nth_conv_o, tile_idx_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("after_rst idle", 32'(busy_o | wgt_req_o | done_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
